// File: rtl/control_fsm.sv
// control_fsm: multicycle processor control FSM with a bounded memory-wait timeout.
// Define CTRL_ILLEGAL_TRAP_EN to park unknown opcodes in TRAP until reset.
module control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       pc_src,
    output logic       mem_err,
    output logic       illegal,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state
);
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
                           MEM_WB = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
                           ALU_WB = 4'd8, BRANCH = 4'd9, TRAP = 4'd10;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011;
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] ON_ILLEGAL = TRAP;
    assign illegal = state == TRAP;
`else
    localparam logic [3:0] ON_ILLEGAL = FETCH;
    assign illegal = 1'b0;
`endif
    logic [3:0] next_state;
    logic [7:0] cnt;
    logic       waiting;
    logic       timeout;
    assign waiting = state == FETCH || state == MEM_RD || state == MEM_WR;
    assign timeout = rst_n && waiting && !mem_ready && cnt == LIMIT;
    assign mem_err = timeout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (waiting && !mem_ready && !timeout) ? cnt + 8'd1 : 8'd0;
        end
    end
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE:   next_state = (opcode == OP_LOAD || opcode == OP_STORE) ? MEM_ADDR :
                                   opcode == OP_R  ? EXEC_R :
                                   opcode == OP_I  ? EXEC_I :
                                   opcode == OP_BR ? BRANCH : ON_ILLEGAL;
            MEM_ADDR: next_state = opcode == OP_LOAD ? MEM_RD : MEM_WR;
            MEM_RD:   next_state = mem_ready ? MEM_WB : timeout ? FETCH : MEM_RD;
            MEM_WR:   next_state = (mem_ready || timeout) ? FETCH : MEM_WR;
            EXEC_R:   next_state = ALU_WB;
            EXEC_I:   next_state = ALU_WB;
            TRAP:     next_state = ON_ILLEGAL;
            default:  next_state = FETCH;
        endcase
    end
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
            end
            DECODE:   alu_src_b = 2'b10;
            MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = !timeout;
                i_or_d    = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            ALU_WB:   reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = !zero;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: random instruction stream checked against a per-instruction step-plan model.
module tb_control_fsm;
    localparam int T = 4;
    logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
    logic [6:0] opcode = '0;
    logic pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg, pc_src, mem_err, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;
    int n_checks = 0, n_pass = 0;
    int plan[$];
    int waited = 0, rdy_pct = 100, trap_cycles = 0, cur;
    logic [6:0] op = '0;
    logic to;

    control_fsm #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
        .mem_err(mem_err), .illegal(illegal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] outs();
        return {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg, pc_src,
                mem_err, illegal, alu_src_a, alu_src_b, alu_op};
    endfunction

    // Expected control word for a step: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_RD=3 MEM_WB=4
    // MEM_WR=5 EXEC_R=6 EXEC_I=7 ALU_WB=8 BRANCH=9 TRAP=10.
    function automatic logic [15:0] exp_outs(input int s, input logic rdy, input logic z, input logic t);
        logic pw = 0, iw = 0, mr = 0, mw = 0, iod = 0, rw = 0, m2r = 0, ps = 0, ill = 0;
        logic [1:0] a = 0, b = 0, aop = 0;
        case (s)
            0: begin mr = 1; b = 2'b01; iw = rdy; pw = rdy; end
            1: b = 2'b10;
            2: begin a = 2'b01; b = 2'b10; end
            3: begin mr = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mw = !t; iod = 1; end
            6: begin a = 2'b01; aop = 2'b10; end
            7: begin a = 2'b01; b = 2'b10; aop = 2'b10; end
            8: rw = 1;
            9: begin a = 2'b01; aop = 2'b01; ps = 1; pw = !z; end
            10: ill = 1;
            default: ;
        endcase
        return {pw, iw, mr, mw, iod, rw, m2r, ps, t, ill, a, b, aop};
    endfunction

    task automatic new_instr();
        int k = $urandom_range(0, 5);
        int pcts[3] = '{30, 60, 100};
        rdy_pct = pcts[$urandom_range(0, 2)];
        case (k)
            0: begin op = 7'b0000011; plan = '{0, 1, 2, 3, 4}; end
            1: begin op = 7'b0100011; plan = '{0, 1, 2, 5}; end
            2: begin op = 7'b0110011; plan = '{0, 1, 6, 8}; end
            3: begin op = 7'b0010011; plan = '{0, 1, 7, 8}; end
            4: begin op = 7'b1100011; plan = '{0, 1, 9}; end
            default: begin
                op = 7'($urandom_range(0, 127));
                if (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011}) op = 7'h7f;
`ifdef CTRL_ILLEGAL_TRAP_EN
                plan = '{0, 1, 10};
`else
                plan = '{0, 1};
`endif
            end
        endcase
    endtask

    initial begin
        #1;
        check("reset_state", 32'(state), 0);
        check("reset_outs", 32'(outs()), 32'(exp_outs(0, 1'b0, 1'b0, 1'b0)));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (plan.size() == 0) new_instr();
            opcode = op;
            mem_ready = $urandom_range(0, 99) < rdy_pct;
            zero = 1'($urandom_range(0, 1));
            #1;
            cur = plan[0];
            to = cur inside {0, 3, 5} && !mem_ready && waited == T - 1;
            check("state", 32'(state), 32'(cur));
            check("outs", 32'(outs()), 32'(exp_outs(cur, mem_ready, zero, to)));
            trap_cycles = cur == 10 ? trap_cycles + 1 : 0;
            if ($urandom_range(0, 79) == 0 || trap_cycles > 3) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_state", 32'(state), 0);
                check("async_rst_mem_write", 32'(mem_write), 0);
                check("async_rst_reg_write", 32'(reg_write), 0);
                check("async_rst_illegal", 32'(illegal), 0);
                plan.delete();
                waited = 0;
                trap_cycles = 0;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            @(posedge clk);
            if (cur inside {0, 3, 5}) begin
                if (mem_ready) begin
                    void'(plan.pop_front());
                    waited = 0;
                end else if (to) begin
                    plan.delete();
                    waited = 0;
                end else waited++;
            end else if (cur != 10) void'(plan.pop_front());
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
